fsm_input_debouncer: RTL and testbench

Two-channel input conditioner placed directly upstream of the 3-state a/b sequence FSM. It takes raw asynchronous switch/pushbutton levels, synchronizes them to clk, debounces them, and drives the clean a and b levels the FSM samples. It also emits one-cycle edge ticks for counters and loggers.

---
 rtl/fsm_io_defs.sv | 18 +
 rtl/debounce_channel.sv | 101 ++++++++++
 rtl/fsm_input_debouncer.sv | 42 ++++
 tb/tb_fsm_input_debouncer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_io_defs.sv
// rtl/fsm_io_defs.sv - shared state encoding and defaults for the input debouncer
//
// Purpose: state encoding of the per-channel debounce FSM and the default
//          debounce length, shared by debounce_channel and fsm_input_debouncer.
// Ports:   none (package).
package fsm_io_defs;

  // Bit 1 of the encoding is the debounced level: ONE and WAIT0 drive 1.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  localparam int DB_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one synchronized, debounced input channel with edge ticks
//
// Purpose: two-flop synchronizer, 4-state debounce FSM with a stability
//          counter, and registered one-cycle rise/fall ticks.
// Ports:   clk     - system clock, posedge
//          reset_n - asynchronous active-low reset
//          raw     - raw asynchronous input level
//          level   - debounced level (bit 1 of the state register)
//          rise    - one-cycle pulse in the first cycle level is 1
//          fall    - one-cycle pulse in the first cycle level is 0
module debounce_channel
  import fsm_io_defs::*;
#(
  parameter  int DB_CYCLES = DB_CYCLES_DEF,
  localparam int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  // DB_CYCLES-1 always fits in $clog2(DB_CYCLES) bits, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (s2_q) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s2_q) begin
          state_d = ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ONE;
          rise_d  = 1'b1;   // ticks are registered alongside the state change
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!s2_q) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s2_q) begin
          state_d = ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = state_q[1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/fsm_input_debouncer.sv
// rtl/fsm_input_debouncer.sv - two independent debounce channels feeding the a/b sequence FSM
//
// Purpose: conditions raw switch levels raw_a/raw_b into clean levels a/b
//          plus one-cycle edge ticks.
// Ports:   clk, reset_n (async active-low), raw_a, raw_b,
//          a, b (debounced levels), a_rise, a_fall, b_rise, b_fall (ticks)
module fsm_input_debouncer
  import fsm_io_defs::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_a),
    .level   (a),
    .rise    (a_rise),
    .fall    (a_fall)
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_b),
    .level   (b),
    .rise    (b_rise),
    .fall    (b_fall)
  );

endmodule

// File: tb/tb_fsm_input_debouncer.sv
// tb/tb_fsm_input_debouncer.sv - directed self-checking bench for fsm_input_debouncer
module tb_fsm_input_debouncer;

  localparam int DB = 16;
  // Edge 0 is the first edge that samples a new raw level; the output changes
  // at edge DB+2, which is observed after DB+3 steps.
  localparam int LAT_STEPS = DB + 3;

  logic clk = 1'b0;
  logic reset_n;
  logic raw_a, raw_b;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  int vectors = 0;
  int miscompares = 0;

  int a_first, a_last, b_first, b_last;
  int a_rise_n, a_fall_n, b_rise_n, b_fall_n, tick_bad;
  int bounce_chg;

  always #5 clk = ~clk;

  fsm_input_debouncer #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .a       (a),
    .b       (b),
    .a_rise  (a_rise),
    .a_fall  (a_fall),
    .b_rise  (b_rise),
    .b_fall  (b_fall)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step n cycles, recording first/last step index at which each level
  // changed, tick counts, and any tick not matching a level edge.
  task automatic run(input int n);
    logic a_prev, b_prev;
    a_first = -1; a_last = -1; b_first = -1; b_last = -1;
    a_rise_n = 0; a_fall_n = 0; b_rise_n = 0; b_fall_n = 0; tick_bad = 0;
    for (int i = 1; i <= n; i++) begin
      a_prev = a;
      b_prev = b;
      step();
      if (a !== a_prev) begin
        if (a_first < 0) a_first = i;
        a_last = i;
      end
      if (b !== b_prev) begin
        if (b_first < 0) b_first = i;
        b_last = i;
      end
      if (a_rise) a_rise_n++;
      if (a_fall) a_fall_n++;
      if (b_rise) b_rise_n++;
      if (b_fall) b_fall_n++;
      if (a_rise !== (a & ~a_prev)) tick_bad++;
      if (a_fall !== (~a & a_prev)) tick_bad++;
      if (b_rise !== (b & ~b_prev)) tick_bad++;
      if (b_fall !== (~b & b_prev)) tick_bad++;
    end
  endtask

  function automatic int outs();
    return {26'd0, a, b, a_rise, a_fall, b_rise, b_fall};
  endfunction

  initial begin
    raw_a = 1'b0;
    raw_b = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check("reset_async_outs", outs(), 0);
    step();
    step();
    check("reset_held_outs", outs(), 0);
    reset_n = 1'b1;

    // Quiet inputs: nothing moves for 50 cycles.
    run(50);
    check("idle_a_chg", a_first, -1);
    check("idle_b_chg", b_first, -1);
    check("idle_ticks", a_rise_n + a_fall_n + b_rise_n + b_fall_n, 0);
    check("idle_outs", outs(), 0);

    // Clean rise on A, then clean fall.
    raw_a = 1'b1;
    run(LAT_STEPS);
    check("rise_a_at", a_first, LAT_STEPS);
    check("rise_a_rise_n", a_rise_n, 1);
    check("rise_b_chg", b_first, -1);
    check("rise_tick_ok", tick_bad, 0);
    raw_a = 1'b0;
    run(LAT_STEPS);
    check("fall_a_at", a_first, LAT_STEPS);
    check("fall_a_fall_n", a_fall_n, 1);
    check("fall_a_rise_n", a_rise_n, 0);

    // Bounce: toggle every 3 cycles for 30 cycles, then settle high.
    bounce_chg = 0;
    for (int k = 0; k < 10; k++) begin
      raw_a = (k % 2 == 0);
      run(3);
      bounce_chg += a_rise_n + a_fall_n + ((a_first >= 0) ? 1 : 0);
    end
    check("bounce_no_change", bounce_chg, 0);
    raw_a = 1'b1;
    run(LAT_STEPS);
    check("bounce_settle_at", a_first, LAT_STEPS);
    check("bounce_rise_n", a_rise_n, 1);
    raw_a = 1'b0;
    run(LAT_STEPS + 2);
    check("bounce_back_low", {31'd0, a}, 0);

    // Glitch width on B: DB-1 samples rejected.
    raw_b = 1'b1;
    run(DB - 1);
    raw_b = 1'b0;
    run(30);
    check("glitch15_b_chg", b_first, -1);
    check("glitch15_ticks", b_rise_n + b_fall_n, 0);

    // DB+1 samples accepted: rise at edge DB+2 (step 2 after the pulse),
    // fall 18 edges after raw falls (edge DB+1+DB+2 = step DB+3 after the pulse).
    raw_b = 1'b1;
    run(DB + 1);
    check("glitch17_early", b_first, -1);
    raw_b = 1'b0;
    run(LAT_STEPS);
    check("glitch17_rise_at", b_first, 2);
    check("glitch17_fall_at", b_last, LAT_STEPS);
    check("glitch17_rise_n", b_rise_n, 1);
    check("glitch17_fall_n", b_fall_n, 1);
    check("glitch17_tick_ok", tick_bad, 0);

    // Simultaneous rise on both channels, then A falls alone.
    raw_a = 1'b1;
    raw_b = 1'b1;
    run(LAT_STEPS);
    check("simul_a_at", a_first, LAT_STEPS);
    check("simul_b_at", b_first, LAT_STEPS);
    check("simul_ticks", a_rise_n * 10 + b_rise_n, 11);
    check("simul_tick_ok", tick_bad, 0);
    raw_a = 1'b0;
    run(LAT_STEPS);
    check("afall_a_at", a_first, LAT_STEPS);
    check("afall_b_chg", b_first, -1);
    check("afall_ticks", a_fall_n * 10 + b_fall_n, 10);
    check("afall_b_level", {31'd0, b}, 1);

    // Reset in WAIT1 with cnt=8: WAIT1 entered at edge 2, cnt=8 after edge 10.
    raw_a = 1'b1;
    run(11);
    check("mid_a_still0", {31'd0, a}, 0);
    #2 reset_n = 1'b0;
    #1 check("mid_reset_outs", outs(), 0);
    step();
    step();
    reset_n = 1'b1;
    run(LAT_STEPS);
    check("mid_release_a_at", a_first, LAT_STEPS);
    check("mid_release_b_at", b_first, LAT_STEPS);
    check("mid_release_a_rise", a_rise_n, 1);
    check("mid_release_tick_ok", tick_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
